// File: rtl/decoder_2x4_pkg.sv
// rtl/decoder_2x4_pkg.sv - shared select type, line constants and one-hot helper for decoder_2x4
package decoder_2x4_pkg;

   // Two-bit select formed as {A,B}
   typedef logic [1:0] sel_t;

   localparam int NUM_LINES = 4;

   localparam sel_t SEL_D0 = 2'd0;
   localparam sel_t SEL_D1 = 2'd1;
   localparam sel_t SEL_D2 = 2'd2;
   localparam sel_t SEL_D3 = 2'd3;

   // One-hot image of a select code; bit n set for code n
   function automatic logic [NUM_LINES-1:0] decode_sel(input sel_t s);
      logic [NUM_LINES-1:0] r;
      r    = '0;
      r[s] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/decoder_2x4_sat_cnt.sv
// rtl/decoder_2x4_sat_cnt.sv - single saturating hit counter with synchronous clear
module decoder_2x4_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = '1;

   // Reset and clear both zero the count; increments stop at the all-ones value
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/decoder_2x4.sv
// rtl/decoder_2x4.sv - registered 2-to-4 decoder; DECODER_2X4_CNT_EN adds per-line hit counters
module decoder_2x4
   import decoder_2x4_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A,
   input  logic             B,
   input  logic             en,
   output logic             D0,
   output logic             D1,
   output logic             D2,
   output logic             D3,
   output logic             any_o,
   output logic [1:0]       idx_o
`ifdef DECODER_2X4_CNT_EN
   ,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt3
`endif
);

   if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
      $error("decoder_2x4: CNT_W must be in 1..32");
   end

   sel_t                 sel;
   logic [NUM_LINES-1:0] line_q;
   logic                 any_q;
   sel_t                 idx_q;

   assign sel = {A, B};

   // Decode on the clock edge; A/B are only looked at when enabled so X selects stay out of the lines
   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
         any_q  <= 1'b0;
         idx_q  <= SEL_D0;
      end else if (en) begin
         line_q <= decode_sel(sel);
         any_q  <= 1'b1;
         idx_q  <= sel;
      end else begin
         line_q <= '0;
         any_q  <= 1'b0;
      end
   end

   assign D0    = line_q[SEL_D0];
   assign D1    = line_q[SEL_D1];
   assign D2    = line_q[SEL_D2];
   assign D3    = line_q[SEL_D3];
   assign any_o = any_q;
   assign idx_o = idx_q;

`ifdef DECODER_2X4_CNT_EN
   logic [CNT_W-1:0] cnt_q [NUM_LINES];

   for (genvar i = 0; i < NUM_LINES; i++) begin : g_cnt
      logic hit;

      // A hit is the line being asserted by this edge, i.e. enabled with a matching select
      assign hit = en && (sel == sel_t'(i));

      decoder_2x4_sat_cnt #(
         .W   (CNT_W)
      ) u_cnt (
         .clk (clk),
         .rst (rst),
         .clr (cnt_clr),
         .inc (hit),
         .cnt (cnt_q[i])
      );
   end

   assign cnt0 = cnt_q[SEL_D0];
   assign cnt1 = cnt_q[SEL_D1];
   assign cnt2 = cnt_q[SEL_D2];
   assign cnt3 = cnt_q[SEL_D3];
`endif

endmodule

// File: tb/tb_decoder_2x4.sv
// tb/tb_decoder_2x4.sv - scoreboard bench for decoder_2x4, counter checks when DECODER_2X4_CNT_EN is set
module tb_decoder_2x4;

`ifdef DECODER_2X4_CNT_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 8;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             A;
   logic             B;
   logic             en;
   logic             D0;
   logic             D1;
   logic             D2;
   logic             D3;
   logic             any_o;
   logic [1:0]       idx_o;
`ifdef DECODER_2X4_CNT_EN
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
   logic [CNT_W-1:0] cnt2;
   logic [CNT_W-1:0] cnt3;
`endif

   always #5 clk = ~clk;

   decoder_2x4 #(
      .CNT_W   (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .A       (A),
      .B       (B),
      .en      (en),
      .D0      (D0),
      .D1      (D1),
      .D2      (D2),
      .D3      (D3),
      .any_o   (any_o),
      .idx_o   (idx_o)
`ifdef DECODER_2X4_CNT_EN
      ,
      .cnt_clr (cnt_clr),
      .cnt0    (cnt0),
      .cnt1    (cnt1),
      .cnt2    (cnt2),
      .cnt3    (cnt3)
`endif
   );

   typedef struct {
      logic [3:0]            d;
      logic                  any;
      logic [1:0]            idx;
      logic [3:0][CNT_W-1:0] c;
   } exp_t;

   exp_t                  sb[$];
   logic [1:0]            m_idx;
   logic [3:0][CNT_W-1:0] m_c;
   logic [CNT_W-1:0]      m_max;
   int                    n_cmp = 0;
   int                    n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic a, input logic b, input logic e,
                       input logic clr, input string tag);
      exp_t x;
      exp_t got;
      int   s;
      rst = r;
      A   = a;
      B   = b;
      en  = e;
`ifdef DECODER_2X4_CNT_EN
      cnt_clr = clr;
`endif
      if (r) begin
         x.d   = 4'b0000;
         x.any = 1'b0;
         m_idx = 2'b00;
         m_c   = '0;
      end else begin
         if (e) begin
            s     = (a ? 2 : 0) + (b ? 1 : 0);
            x.d   = 4'b0001 << s;
            x.any = 1'b1;
            m_idx = 2'(s);
            if (!clr && (m_c[s] != m_max)) m_c[s] = m_c[s] + 1'b1;
         end else begin
            x.d   = 4'b0000;
            x.any = 1'b0;
         end
         if (clr) m_c = '0;
      end
      x.idx = m_idx;
      x.c   = m_c;
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         got = sb.pop_front();
         chk({tag, ".d"}, {28'd0, D3, D2, D1, D0}, {28'd0, got.d});
         chk({tag, ".any"}, {31'd0, any_o}, {31'd0, got.any});
         chk({tag, ".idx"}, {30'd0, idx_o}, {30'd0, got.idx});
         chk({tag, ".onehot0"}, {31'd0, $onehot0({D3, D2, D1, D0})}, 32'd1);
`ifdef DECODER_2X4_CNT_EN
         chk({tag, ".cnt0"}, 32'(cnt0), 32'(got.c[0]));
         chk({tag, ".cnt1"}, 32'(cnt1), 32'(got.c[1]));
         chk({tag, ".cnt2"}, 32'(cnt2), 32'(got.c[2]));
         chk({tag, ".cnt3"}, 32'(cnt3), 32'(got.c[3]));
`endif
      end
   endtask

   initial begin
      m_max = '1;
      m_idx = 2'b00;
      m_c   = '0;
      rst   = 1'b1;
      A     = 1'b0;
      B     = 1'b0;
      en    = 1'b0;
`ifdef DECODER_2X4_CNT_EN
      cnt_clr = 1'b0;
`endif
      @(negedge clk);

      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "reset0");
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "reset1");

      for (int i = 0; i < 8; i++) begin
         step(1'b0, i[2], i[1], i[0], 1'b0, $sformatf("sweep%0d", i));
      end

      step(1'b0, 1'bx, 1'bx, 1'b0, 1'b0, "xsel_dis");

      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "b2b_11");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_00");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "b2b_10");

      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "mid_pre");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "mid_rst");
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "mid_post");

`ifdef DECODER_2X4_CNT_EN
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "cnt_rst");
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, $sformatf("sat%0d", i));
      end
      chk("sat_final", 32'(cnt2), 32'd3);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "clr_hit");
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "hit3");
      chk("hit3_final", 32'(cnt3), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
